// File: rtl/uart_mode_ctrl.sv
// Escape-sequence parser and mode sequencer between UART RX and the loopback FIFO.
// Define UART_MODE_ACK_EN to compile in the ACK state that sends ACK_BYTE after a mode change.
module uart_mode_ctrl #(
    parameter logic [3:0]  DEFAULT_MODE    = 4'd1,
    parameter int unsigned ESC_TIMEOUT_CYC = 500000,
    parameter int unsigned SETTLE_CYC      = 1024,
    parameter logic [7:0]  ACK_BYTE        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] fwd_data,
    output logic       fwd_valid,
    input  logic       fifo_empty,
    input  logic       tx_ready,
    output logic       tx_grant_fifo,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    output logic [3:0] mode,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int unsigned TMO_W = $clog2(ESC_TIMEOUT_CYC + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ESC_TIMEOUT_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_DRAIN,
        S_APPLY,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t           state_q;
    logic [3:0]       mode_q;
    logic [3:0]       new_mode_q;
    logic [7:0]       fwd_data_q;
    logic             fwd_valid_q;
    logic [7:0]       pend_q;
    logic             pend_valid_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic             grant_q;
    logic             busy_q;
    logic [7:0]       drop_cnt_q;
    logic             busy_state;
`ifdef UART_MODE_ACK_EN
    logic             ack_valid_q;
    logic [7:0]       ack_data_q;
`endif

    assign busy_state = (state_q != S_IDLE) && (state_q != S_ESC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= DEFAULT_MODE;
            new_mode_q   <= '0;
            fwd_data_q   <= '0;
            fwd_valid_q  <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            grant_q      <= 1'b1;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef UART_MODE_ACK_EN
            ack_valid_q  <= 1'b0;
            ack_data_q   <= '0;
`endif
        end else begin
            fwd_valid_q <= 1'b0;
            busy_q      <= busy_state;

            if (pend_valid_q) begin
                fwd_valid_q  <= 1'b1;
                fwd_data_q   <= pend_q;
                pend_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == 8'hFF) begin
                            state_q   <= S_ESC;
                            tmo_cnt_q <= '0;
                        end else if (pend_valid_q) begin
                            // Forward slot is taken by the pending byte; queue behind it.
                            pend_q       <= rx_data;
                            pend_valid_q <= 1'b1;
                        end else begin
                            fwd_valid_q <= 1'b1;
                            fwd_data_q  <= rx_data;
                        end
                    end
                end
                S_ESC: begin
                    if (rx_valid) begin
                        state_q <= S_IDLE;
                        if (rx_data == 8'hFF) begin
                            fwd_valid_q <= 1'b1;
                            fwd_data_q  <= 8'hFF;
                        end else if (rx_data[7:4] == 4'hF) begin
                            new_mode_q <= rx_data[3:0];
                            state_q    <= S_DRAIN;
                        end else begin
                            fwd_valid_q  <= 1'b1;
                            fwd_data_q   <= 8'hFF;
                            pend_q       <= rx_data;
                            pend_valid_q <= 1'b1;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        fwd_valid_q <= 1'b1;
                        fwd_data_q  <= 8'hFF;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && tx_ready) begin
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    mode_q       <= new_mode_q;
                    grant_q      <= 1'b0;
                    settle_cnt_q <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SET_LAST) begin
`ifdef UART_MODE_ACK_EN
                        state_q     <= S_ACK;
                        ack_valid_q <= 1'b1;
                        ack_data_q  <= ACK_BYTE;
`else
                        state_q <= S_IDLE;
                        grant_q <= 1'b1;
`endif
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
`ifdef UART_MODE_ACK_EN
                S_ACK: begin
                    if (ack_valid_q && tx_ready) begin
                        state_q     <= S_IDLE;
                        ack_valid_q <= 1'b0;
                        ack_data_q  <= '0;
                        grant_q     <= 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase

            if (rx_valid && busy_state && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign fwd_data      = fwd_data_q;
    assign fwd_valid     = fwd_valid_q;
    assign tx_grant_fifo = grant_q;
    assign mode          = mode_q;
    assign busy          = busy_q;
    assign drop_cnt      = drop_cnt_q;
`ifdef UART_MODE_ACK_EN
    assign ack_valid     = ack_valid_q;
    assign ack_data      = ack_data_q;
`else
    assign ack_valid     = 1'b0;
    assign ack_data      = ACK_BYTE & 8'h00;
`endif

endmodule

// File: doc/uart_mode_ctrl.md
# uart_mode_ctrl

Controller that sits between the UART RX output and the loopback FIFO and sequences baud/format mode changes for the shared RX/TX pair. It strips the in-band escape sequence `0xFF, 0xFn` from the data stream and forwards all other bytes to the FIFO. On a valid command it drains the FIFO and TX, switches `mode`, waits for the UART to settle and optionally acknowledges over TX. It owns the TX arbitration between FIFO traffic and its own acknowledge byte.

## Interface
Parameters:
- `DEFAULT_MODE`, 4'd1: value of `mode` after reset.
- `ESC_TIMEOUT_CYC`, 500000: cycles in ESC before a lone 0xFF is treated as data.
- `SETTLE_CYC`, 1024: cycles held in SETTLE after a mode change.
- `ACK_BYTE`, 8'hA5: byte sent to the host after a mode change.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  byte from RX.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `fwd_data`  out  8  byte to FIFO `data_in`.
- `fwd_valid`  out  1  one-cycle FIFO write strobe.
- `fifo_empty`  in  1  FIFO empty flag.
- `tx_ready`  in  1  TX can accept a byte.
- `tx_grant_fifo`  out  1  1: FIFO owns TX; 0: this block owns TX.
- `ack_data`  out  8  acknowledge byte, driven to TX when `tx_grant_fifo`=0.
- `ack_valid`  out  1  acknowledge byte valid.
- `mode`  out  4  current UART mode to RX and TX.
- `busy`  out  1  high in any state other than IDLE or ESC.
- `drop_cnt`  out  8  saturating count of bytes dropped while busy.

## Operation
- States: IDLE, ESC, DRAIN, APPLY, SETTLE, ACK.
- IDLE:
  - `rx_valid` with 0xFF: go to ESC, nothing forwarded, start the timeout counter.
  - Any other byte: forward it.
- ESC, on `rx_valid`:
  - 0xFF: forward a single 0xFF, go to IDLE. This is the literal escape.
  - Byte with upper nibble 0xF (0xF0..0xFE): latch the low nibble as `new_mode`, go to DRAIN, nothing forwarded.
  - Any other byte: forward 0xFF, then forward the byte on the next cycle from a 1-byte pending register, go to IDLE.
- ESC timeout: `ESC_TIMEOUT_CYC` cycles with no `rx_valid` forwards 0xFF and returns to IDLE.
- DRAIN: `tx_grant_fifo`=1. When `fifo_empty` && `tx_ready` are sampled high together, go to APPLY.
- APPLY: one cycle. Sets `mode <= new_mode`, sets `tx_grant_fifo`=0, goes to SETTLE.
- SETTLE: counts `SETTLE_CYC` cycles, then goes to ACK.
- ACK: holds `ack_valid`=1 and `ack_data`=`ACK_BYTE` until a cycle with `ack_valid` && `tx_ready`. On that cycle go to IDLE; `ack_valid`=0 and `tx_grant_fifo`=1 from the next cycle.
- A command equal to the current `mode` runs the full sequence anyway.
- Bytes received in DRAIN, APPLY, SETTLE or ACK:
  - Not forwarded.
  - `drop_cnt` increments and saturates at 255.
  - The escape parser is not advanced.

## Timing
- Reset values:
  - State IDLE, `mode`=`DEFAULT_MODE`, `tx_grant_fifo`=1.
  - `fwd_valid`=0, `fwd_data`=0, `ack_valid`=0, `ack_data`=0.
  - `busy`=0, `drop_cnt`=0.
  - Pending register and all counters cleared.
- Reset mid-sequence (any state) takes effect the next cycle. `mode` returns to `DEFAULT_MODE` and any pending or in-flight byte is discarded.
- Forwarding latency: `fwd_valid` is registered and pulses exactly 1 cycle after the qualifying `rx_valid`. The pending byte pulses 2 cycles after it.
- `rx_valid` in the same cycle as the timeout expiring: the byte wins and is parsed as ESC input; no timeout forward occurs.
- `mode` changes only in APPLY, and only after FIFO empty and TX ready. No byte is ever transmitted or received across a mode change under the block's control.
- `busy` is registered and follows the state with 1-cycle latency.
- `drop_cnt` is not cleared by completing a sequence; only `reset` clears it.

## Configuration
- `UART_MODE_ACK_EN` defined:
  - ACK state is compiled in and `ACK_BYTE` is sent after every mode change.
- `UART_MODE_ACK_EN` undefined:
  - SETTLE goes directly to IDLE.
  - `ack_valid` and `ack_data` are tied to 0.
  - `tx_grant_fifo` returns to 1 on the cycle after SETTLE ends.

## Test plan
- Data pass-through: send 0x41, 0x42 → `fwd_valid` pulses with 0x41 then 0x42, each 1 cycle after `rx_valid`; `mode`=1.
- Literal escape: send 0xFF, 0xFF → a single forwarded 0xFF; state IDLE.
- Broken escape: send 0xFF, 0x10 → forward 0xFF, then 0x10 one cycle later.
- Escape timeout: send 0xFF and wait `ESC_TIMEOUT_CYC` cycles → 0xFF forwarded.
- Mode change with drain:
  - Stimulus: FIFO non-empty, send 0xFF, 0xF3.
  - `mode` stays 1 until `fifo_empty`=1 and `tx_ready`=1.
  - Then APPLY sets `mode`=3; `ack_valid` asserts after `SETTLE_CYC` cycles.
  - `ack_valid` drops after the handshake; `tx_grant_fifo`=1.
  - A byte sent during SETTLE gives `drop_cnt`=1 and no `fwd_valid`.
- Reset in SETTLE: assert `reset` for 1 cycle → `mode`=1, IDLE, `ack_valid`=0, `drop_cnt`=0; next 0x55 forwards normally.
